// File: rtl/battle_pkg.sv
// Shared phase codes, state-word field positions and the slider damage rule
// for the battle sequencer.
package battle_pkg;

    typedef enum logic [3:0] {
        PH_MENU   = 4'b0001,
        PH_DODGE  = 4'b1001,
        PH_ATTACK = 4'b1010,
        PH_OVER   = 4'b1100
    } phase_t;

    localparam int unsigned PHASE_LSB  = 28;
    localparam int unsigned HP_LSB     = 20;
    localparam int unsigned SLIDER_LSB = 10;
    localparam int unsigned CNT_LSB    = 0;

    // Damage falls off by one point per 4 pixels of distance from the target.
    function automatic logic [7:0] calc_dmg(input logic [9:0] x,
                                            input logic [9:0] ctr,
                                            input logic [7:0] max_dmg);
        logic [9:0] d;
        logic [9:0] q;
        d = (x >= ctr) ? (x - ctr) : (ctr - x);
        q = d >> 2;
        return (q >= {2'b00, max_dmg}) ? 8'd0 : (max_dmg - q[7:0]);
    endfunction

endpackage

// File: rtl/vsync_edge.sv
// Samples vsync and produces a registered one-cycle pulse on its rising edge.
module vsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync & ~vsync_q;
        end
    end

endmodule

// File: rtl/battle_seq.sv
// Frame-synchronous battle phase sequencer driving the renderer state word.
// Defining BATTLE_SEQ_PAUSE_EN adds a pause input that freezes progression on frame ticks.
module battle_seq
    import battle_pkg::*;
#(
    parameter int unsigned DODGE_FRAMES = 600,
    parameter int unsigned GRACE_FRAMES = 30,
    parameter int unsigned ENEMY_HP     = 100,
    parameter int unsigned SLIDE_MIN    = 217,
    parameter int unsigned SLIDE_MAX    = 423,
    parameter int unsigned SLIDE_CTR    = 320,
    parameter int unsigned SLIDE_STEP   = 3,
    parameter int unsigned MAX_DMG      = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        start,
    input  logic        fire,
    input  logic        hp_zero,
`ifdef BATTLE_SEQ_PAUSE_EN
    input  logic        pause,
`endif
    output logic [31:0] state,
    output logic        isRender,
    output logic        win,
    output logic        frame_tick
);

    localparam logic [9:0]  CNT_LAST = 10'(DODGE_FRAMES - 1);
    localparam logic [9:0]  GRACE    = 10'(GRACE_FRAMES);
    localparam logic [7:0]  HP_INIT  = 8'(ENEMY_HP);
    localparam logic [9:0]  X_MIN    = 10'(SLIDE_MIN);
    localparam logic [10:0] X_MAX    = 11'(SLIDE_MAX);
    localparam logic [9:0]  X_CTR    = 10'(SLIDE_CTR);
    localparam logic [10:0] X_STEP   = 11'(SLIDE_STEP);
    localparam logic [7:0]  DMG_MAX  = 8'(MAX_DMG);

    phase_t      phase, phase_n;
    logic [7:0]  hp, hp_n, hp_left, dmg;
    logic [9:0]  slider, slider_n, cnt, cnt_n;
    logic [10:0] step_sum;
    logic        win_n, render_n, resolve, hold;
    logic        start_flag, fire_flag, start_seen, fire_seen;

    vsync_edge u_vsync_edge (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

`ifdef BATTLE_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        start_seen = start_flag | start;
        fire_seen  = fire_flag | fire;
        step_sum   = {1'b0, slider} + X_STEP;
        dmg        = '0;
        resolve    = 1'b0;
        hp_left    = hp;
        phase_n    = phase;
        hp_n       = hp;
        slider_n   = slider;
        cnt_n      = cnt;
        win_n      = win;
        if (frame_tick && !hold) begin
            case (phase)
                PH_MENU: begin
                    if (start_seen) begin
                        phase_n = PH_DODGE;
                        hp_n    = HP_INIT;
                        cnt_n   = '0;
                        win_n   = 1'b0;
                    end
                end
                PH_DODGE: begin
                    if (hp_zero) begin
                        phase_n = PH_OVER;
                        win_n   = 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        phase_n  = PH_ATTACK;
                        slider_n = X_MIN;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + 10'd1;
                    end
                end
                PH_ATTACK: begin
                    // A miss is resolved as a zero-damage hit so both share the exit path.
                    if (fire_seen) begin
                        resolve = 1'b1;
                        dmg     = calc_dmg(slider, X_CTR, DMG_MAX);
                    end else if (step_sum > X_MAX) begin
                        resolve = 1'b1;
                    end else begin
                        slider_n = step_sum[9:0];
                    end
                    if (resolve) begin
                        hp_left = (hp > dmg) ? (hp - dmg) : '0;
                        hp_n    = hp_left;
                        if (hp_left == '0) begin
                            phase_n = PH_OVER;
                            win_n   = 1'b1;
                        end else begin
                            phase_n = PH_DODGE;
                            cnt_n   = '0;
                        end
                    end
                end
                PH_OVER: begin
                    if (start_seen) begin
                        phase_n  = PH_MENU;
                        slider_n = X_MIN;
                        cnt_n    = '0;
                    end
                end
                default: phase_n = PH_MENU;
            endcase
        end
        render_n = (phase_n == PH_DODGE) && (cnt_n >= GRACE) && !hold;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= PH_MENU;
            hp         <= HP_INIT;
            slider     <= X_MIN;
            cnt        <= '0;
            win        <= 1'b0;
            isRender   <= 1'b0;
            start_flag <= 1'b0;
            fire_flag  <= 1'b0;
        end else begin
            phase    <= phase_n;
            hp       <= hp_n;
            slider   <= slider_n;
            cnt      <= cnt_n;
            win      <= win_n;
            isRender <= render_n;
            if (frame_tick) begin
                start_flag <= 1'b0;
                fire_flag  <= 1'b0;
            end else begin
                start_flag <= start_flag | start;
                fire_flag  <= fire_flag | fire;
            end
        end
    end

    always_comb begin
        state                      = '0;
        state[PHASE_LSB +: 4]      = phase;
        state[HP_LSB +: 8]         = hp;
        state[SLIDER_LSB +: 10]    = slider;
        state[CNT_LSB +: 10]       = cnt;
    end

endmodule

// File: tb/tb_battle_seq.sv
// Self-checking bench for battle_seq: directed vector table, phase sequences and
// randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_battle_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vsync = 1'b0;
    logic        start = 1'b0;
    logic        fire = 1'b0;
    logic        hp_zero = 1'b0;
    logic [31:0] state;
    logic        isRender, win, frame_tick;
`ifdef BATTLE_SEQ_PAUSE_EN
    logic        pause = 1'b0;
`endif

    always #5 clk = ~clk;

    battle_seq dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .start      (start),
        .fire       (fire),
        .hp_zero    (hp_zero),
`ifdef BATTLE_SEQ_PAUSE_EN
        .pause      (pause),
`endif
        .state      (state),
        .isRender   (isRender),
        .win        (win),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int fails  = 0;

    // Frame-level model: 0 menu, 1 dodge, 2 attack, 3 over
    int unsigned code[4];
    int m_phase, m_hp, m_x, m_cnt, m_win;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_hp = 100; m_x = 217; m_cnt = 0; m_win = 0;
    endtask

    function automatic logic [31:0] model_state();
        return 32'(code[m_phase]) * 32'h1000_0000 + 32'(m_hp) * 32'h10_0000
             + 32'(m_x) * 32'h400 + 32'(m_cnt);
    endfunction

    task automatic model_step(input bit s, input bit f, input bit hz);
        int d, dmg;
        bit done;
        done = 0;
        dmg = 0;
        case (m_phase)
            0: if (s) begin m_phase = 1; m_hp = 100; m_cnt = 0; m_win = 0; end
            1: begin
                if (hz) begin m_phase = 3; m_win = 0; end
                else if (m_cnt == 599) begin m_phase = 2; m_x = 217; m_cnt = 0; end
                else m_cnt++;
            end
            2: begin
                if (f) begin
                    d = (m_x > 320) ? m_x - 320 : 320 - m_x;
                    dmg = (d / 4 >= 25) ? 0 : 25 - d / 4;
                    done = 1;
                end else if (m_x + 3 > 423) done = 1;
                else m_x += 3;
                if (done) begin
                    m_hp = (m_hp > dmg) ? m_hp - dmg : 0;
                    if (m_hp == 0) begin m_phase = 3; m_win = 1; end
                    else begin m_phase = 1; m_cnt = 0; end
                end
            end
            default: if (s) begin m_phase = 0; m_x = 217; m_cnt = 0; end
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, state, model_state());
        check({tag, "_render"}, 32'(isRender), 32'((m_phase == 1) && (m_cnt >= 30)));
        check({tag, "_win"}, 32'(win), 32'(m_win));
    endtask

    // pos: 0 = no pulse, 1 = before vsync, 2 = during the frame_tick cycle
    task automatic do_frame(input int s_pos, input int f_pos, input bit hz, input bit use_model);
        hp_zero = hz;
        if (s_pos == 1) start = 1'b1;
        if (f_pos == 1) fire = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fire = 1'b0; vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        check("tick_high", 32'(frame_tick), 32'd1);
        if (s_pos == 2) start = 1'b1;
        if (f_pos == 2) fire = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fire = 1'b0;
        check("tick_low", 32'(frame_tick), 32'd0);
        model_step(s_pos != 0, f_pos != 0, hz);
        if (use_model) check_model("frame");
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) do_frame(0, 0, 1'b0, 1'b1);
    endtask

    typedef struct {
        int          s;
        int          f;
        bit          hz;
        logic [31:0] st;
        bit          rnd;
        bit          w;
    } vec_t;

    vec_t vecs[10];

    initial begin
        code[0] = 1; code[1] = 9; code[2] = 10; code[3] = 12;
        vecs[0] = '{0, 0, 1'b0, 32'h1643_6400, 1'b0, 1'b0};
        vecs[1] = '{0, 0, 1'b0, 32'h1643_6400, 1'b0, 1'b0};
        vecs[2] = '{0, 0, 1'b0, 32'h1643_6400, 1'b0, 1'b0};
        vecs[3] = '{0, 1, 1'b0, 32'h1643_6400, 1'b0, 1'b0};
        vecs[4] = '{1, 0, 1'b0, 32'h9643_6400, 1'b0, 1'b0};
        vecs[5] = '{0, 1, 1'b0, 32'h9643_6401, 1'b0, 1'b0};
        vecs[6] = '{1, 0, 1'b0, 32'h9643_6402, 1'b0, 1'b0};
        vecs[7] = '{0, 0, 1'b1, 32'hC643_6402, 1'b0, 1'b0};
        vecs[8] = '{0, 0, 1'b0, 32'hC643_6402, 1'b0, 1'b0};
        vecs[9] = '{2, 0, 1'b0, 32'h1643_6400, 1'b0, 1'b0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", state, 32'h1643_6400);
        check("reset_render", 32'(isRender), 32'd0);
        check("reset_win", 32'(win), 32'd0);
        check("reset_tick", 32'(frame_tick), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_frame(vecs[i].s, vecs[i].f, vecs[i].hz, 1'b0);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
            check($sformatf("vec%0d_render", i), 32'(isRender), 32'(vecs[i].rnd));
            check($sformatf("vec%0d_win", i), 32'(win), 32'(vecs[i].w));
        end

        // Dodge entry, grace window and timeout into attack
        do_frame(1, 0, 1'b0, 1'b1);
        frames(29);
        check("grace_29_render", 32'(isRender), 32'd0);
        frames(1);
        check("grace_30_render", 32'(isRender), 32'd1);
        frames(569);
        check("dodge_599", state, 32'h9643_6400 + 32'd599);
        frames(1);
        check("attack_entry", state, 32'hA643_6400);

        // Hit at slider 319
        frames(34);
        check("slider_319", 32'(state[19:10]), 32'd319);
        do_frame(0, 1, 1'b0, 1'b1);
        check("hit_state", state, {4'b1001, 8'd75, 10'd319, 10'd0});

        // Miss after the slider runs out
        frames(600);
        frames(68);
        check("slider_421", state, {4'b1010, 8'd75, 10'd421, 10'd0});
        frames(1);
        check("miss_state", state, {4'b1001, 8'd75, 10'd421, 10'd0});

        // hp_zero wins over the timeout
        frames(599);
        do_frame(0, 0, 1'b1, 1'b1);
        check("hpzero_phase", 32'(state[31:28]), 32'hC);
        check("hpzero_win", 32'(win), 32'd0);
        do_frame(1, 0, 1'b0, 1'b1);
        check("over_to_menu", state, {4'b0001, 8'd75, 10'd217, 10'd0});

        // Four perfect hits defeat the enemy; one fire lands in the tick cycle
        do_frame(1, 0, 1'b0, 1'b1);
        for (int h = 0; h < 4; h++) begin
            frames(600);
            frames(34);
            do_frame(0, (h == 2) ? 2 : 1, 1'b0, 1'b1);
        end
        check("defeat_state", state, {4'b1100, 8'd0, 10'd319, 10'd0});
        check("defeat_win", 32'(win), 32'd1);

        // Start pulse during the tick cycle is taken in that frame
        do_frame(2, 0, 1'b0, 1'b1);
        check("tick_start_menu", 32'(state[31:28]), 32'h1);
        do_frame(1, 0, 1'b0, 1'b1);

        // Reset asserted mid-attack while frame_tick is high
        frames(600);
        frames(10);
        @(posedge clk); #1;
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        check("pre_reset_tick", 32'(frame_tick), 32'd1);
        reset = 1'b0;
        #1;
        check("midreset_state", state, 32'h1643_6400);
        check("midreset_render", 32'(isRender), 32'd0);
        check("midreset_tick", 32'(frame_tick), 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        frames(2);

        // Randomized frames against the model
        for (int i = 0; i < 2500; i++) begin
            int sp, fp;
            bit hz;
            sp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            fp = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 2)) : 0;
            hz = ($urandom_range(0, 799) == 0);
            do_frame(sp, fp, hz, 1'b1);
        end
        hp_zero = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
